disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL, default 100_000_000, meaning clk cycles one requester keeps the display during rotation (legal range 2..2^27-1).
REQ-002 The block SHALL have port clk, input, 1, sole clock, all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 3, per-requester display request, level-sensitive, bit i = requester i.
REQ-005 The block SHALL have ports data0, data1, data2, input, 32 each, 8-nibble BCD word offered by requester i.
REQ-006 The block SHALL have port freeze, input, 1, pins the current grant by suspending dwell expiry.
REQ-007 The block SHALL have port number, output, 32, registered word for the 7-segment multiplexer's number input.
REQ-008 The block SHALL have port active, output, 1, high while any requester is granted.
REQ-009 The block SHALL have port gnt, output, 3, registered one-hot grant, all-zero when idle.
REQ-010 The block SHALL have port src, output, 2, index of granted requester, 2'd0 when idle.
REQ-011 The block SHALL have port done, output, 3, one-cycle pulse on bit i on the edge gnt[i] falls.

Function
REQ-012 The block SHALL implement two states: IDLE (no grant) and SHOW (one requester granted).
REQ-013 The block SHALL keep a 2-bit last-granted pointer; candidate search order SHALL be last+1, last+2, last+3 modulo 3, first set req bit wins.
REQ-014 In IDLE, if any req bit is set at an edge, the block SHALL enter SHOW at that edge with gnt/src set to the chosen requester, last updated, dwell counter cleared.
REQ-015 In IDLE with req=0 the block SHALL stay in IDLE with gnt=0, active=0, number=0.
REQ-016 In SHOW, number SHALL load data[src] every cycle, i.e. number lags the granted data input by exactly one cycle.
REQ-017 In SHOW with freeze=0, the dwell counter SHALL increment each cycle; at count DWELL-1 it SHALL wrap to 0.
REQ-018 At dwell wrap, if another requester is pending, grant SHALL move to the next requester in search order at that edge; if none is pending, the grant SHALL stay with no done pulse.
REQ-019 With freeze=1 the counter SHALL hold its value and no dwell-driven switch SHALL occur.
REQ-020 If req[src] is low at an edge in SHOW, that edge SHALL move the grant to the next pending requester, or to IDLE if none, regardless of freeze or counter; counter SHALL clear.
REQ-021 On every grant change, done SHALL pulse for exactly one cycle on the bit of the requester losing the grant, and the new gnt bit SHALL rise on the same edge.
REQ-022 Grant latency SHALL be one edge: req sampled at edge E gives gnt valid after edge E; number SHALL carry the new source's data after edge E+1.
REQ-023 gnt SHALL never have more than one bit set; active SHALL equal |gnt.

Reset
REQ-024 While rst=1 at an edge, the block SHALL force IDLE, gnt=0, src=0, active=0, number=0, done=0, counter=0, last=2 (so the first search starts at requester 0).
REQ-025 Reset mid-SHOW SHALL dominate all other inputs and SHALL NOT produce a done pulse.

Verification (DWELL=4)
REQ-026 Reset, then req=3'b001, data0=32'h12345678 -> gnt=001 after 1 edge, number=32'h12345678 after 2 edges, held indefinitely with no done pulse.
REQ-027 req=3'b111 from IDLE -> gnt sequence 001,010,100,001, each held 4 cycles, done pulses 001,010,100 on each switch edge.
REQ-028 req=3'b011, freeze=1 during grant to 0 -> gnt stays 001 beyond 4 cycles; freeze=0 -> switch to 010 after the remaining count.
REQ-029 Granted requester 1 drops req[1] at count 1 with req[2] set -> gnt=100 on that edge, done=010 pulse, counter=0; if no other request, IDLE with number=0.
REQ-030 rst=1 asserted mid-SHOW with req=3'b111 -> next edge gnt=0, number=0, done=0; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter
//
// Shares one 7-segment display between three requesters. A requester that
// holds req[i] high competes for the display; grants rotate round-robin,
// each requester keeping the display for DWELL clk cycles while others wait.
// A requester that drops its request loses the grant immediately. freeze
// suspends dwell expiry so the current owner is pinned.
//
// Ports
//   clk     : sole clock, rising edge
//   rst     : synchronous, active-high reset
//   req     : per-requester request, bit i = requester i
//   data0-2 : 8-nibble BCD word offered by each requester
//   freeze  : hold the dwell counter, no dwell-driven switch
//   number  : registered word for the display multiplexer (0 when idle)
//   active  : high while any requester is granted
//   gnt     : registered one-hot grant, zero when idle
//   src     : index of granted requester, 0 when idle
//   done    : one-cycle pulse on the bit of a requester losing the grant
module disp_arbiter #(
    parameter int DWELL = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        freeze,
    output logic [31:0] number,
    output logic        active,
    output logic [2:0]  gnt,
    output logic [1:0]  src,
    output logic [2:0]  done
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     last_q, last_d;
    logic [1:0]     src_q, src_d;
    logic [2:0]     gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    number_d;
    logic [2:0]     done_d;

    logic [1:0]     cand1, cand2, cand3;
    logic           found;
    logic [1:0]     pick;
    logic [31:0]    data_sel;
    logic           req_src;

    // (base + k) mod 3 for base in 0..2 and k in 1..3
    function automatic logic [1:0] step3(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, k};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
        return (i == 2'd2) ? r[2] : ((i == 2'd1) ? r[1] : r[0]);
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // Search order starts just after the last granted requester; the third
    // candidate is the last granted requester itself, so a lone requester
    // is re-selected at dwell expiry and keeps the display.
    assign cand1 = step3(last_q, 2'd1);
    assign cand2 = step3(last_q, 2'd2);
    assign cand3 = step3(last_q, 2'd3);

    always_comb begin
        found = 1'b1;
        pick  = cand1;
        if (req_at(req, cand1)) begin
            pick = cand1;
        end else if (req_at(req, cand2)) begin
            pick = cand2;
        end else if (req_at(req, cand3)) begin
            pick = cand3;
        end else begin
            found = 1'b0;
            pick  = 2'd0;
        end
    end

    assign req_src  = req_at(req, src_q);
    assign data_sel = (src_q == 2'd2) ? data2 : ((src_q == 2'd1) ? data1 : data0);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        src_d    = src_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        done_d   = 3'b000;
        number_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SHOW;
                    src_d   = pick;
                    last_d  = pick;
                    gnt_d   = onehot3(pick);
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (!req_src) begin
                    // Owner withdrew: leave now, whatever freeze or the counter say.
                    cnt_d  = '0;
                    done_d = gnt_q;
                    if (found) begin
                        src_d  = pick;
                        last_d = pick;
                        gnt_d  = onehot3(pick);
                    end else begin
                        state_d = IDLE;
                        src_d   = 2'd0;
                        gnt_d   = 3'b000;
                    end
                end else if (!freeze) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (pick != src_q) begin
                            src_d  = pick;
                            last_d = pick;
                            gnt_d  = onehot3(pick);
                            done_d = gnt_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                // number follows the owner seen this cycle, so it lags a
                // grant change by one cycle and drops to zero on leaving SHOW.
                if (state_d == SHOW) begin
                    number_d = data_sel;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            src_q   <= 2'd0;
            gnt_q   <= 3'b000;
            cnt_q   <= '0;
            number  <= 32'd0;
            done    <= 3'b000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            number  <= number_d;
            done    <= done_d;
        end
    end

    assign gnt    = gnt_q;
    assign src    = src_q;
    assign active = |gnt_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter
//
// Drives disp_arbiter (DWELL=4) through directed scenarios with hand-computed
// expectations, then a long randomized phase. A behavioural model tracks who
// owns the display and for how long; a compare process checks every DUT
// output against it on each falling edge.
module tb_disp_arbiter;

    localparam int DWELL = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] data0, data1, data2;
    logic        freeze;
    logic [31:0] number;
    logic        active;
    logic [2:0]  gnt;
    logic [1:0]  src;
    logic [2:0]  done;

    int checks   = 0;
    int failures = 0;

    disp_arbiter #(.DWELL(DWELL)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data0  (data0),
        .data1  (data1),
        .data2  (data2),
        .freeze (freeze),
        .number (number),
        .active (active),
        .gnt    (gnt),
        .src    (src),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner is the granted requester (-1 when nobody),
    // ptr the last owner, held the cycles the owner has had the display
    // since its grant or last dwell expiry.
    int          m_owner = -1;
    int          m_ptr   = 2;
    int          m_held  = 0;
    logic [31:0] m_number = 32'd0;
    logic [2:0]  m_done   = 3'b000;
    bit          m_valid  = 1'b0;

    always @(posedge clk) begin
        int          winner;
        int          prev;
        int          nxt;
        int          cand;
        logic [31:0] dv [3];
        dv[0] = data0;
        dv[1] = data1;
        dv[2] = data2;
        if (rst) begin
            m_owner  = -1;
            m_ptr    = 2;
            m_held   = 0;
            m_number = 32'd0;
            m_done   = 3'b000;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            winner = -1;
            for (int k = 1; k <= 3; k++) begin
                cand = (m_ptr + k) % 3;
                if (winner < 0 && req[cand]) winner = cand;
            end
            prev = m_owner;
            nxt  = m_owner;
            if (m_owner < 0) begin
                if (winner >= 0) begin
                    nxt    = winner;
                    m_held = 0;
                end
            end else if (!req[m_owner]) begin
                nxt    = winner;
                m_held = 0;
            end else if (!freeze) begin
                if (m_held == DWELL - 1) begin
                    m_held = 0;
                    nxt    = winner;
                end else begin
                    m_held = m_held + 1;
                end
            end
            m_done   = (prev >= 0 && nxt != prev) ? (3'b001 << prev) : 3'b000;
            m_number = (prev >= 0 && nxt >= 0) ? dv[prev] : 32'd0;
            if (nxt >= 0) m_ptr = nxt;
            m_owner = nxt;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_gnt", 32'(gnt),
                        (m_owner < 0) ? 32'd0 : 32'(3'b001 << m_owner));
            checkOutput("model_src", 32'(src), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            checkOutput("model_active", 32'(active), 32'(m_owner >= 0));
            checkOutput("model_number", number, m_number);
            checkOutput("model_done", 32'(done), 32'(m_done));
            checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        end
    end

    task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic fr);
        rst    = r;
        req    = rq;
        freeze = fr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit done_seen;

    initial begin
        data0 = 32'h12345678;
        data1 = 32'hAAAA0001;
        data2 = 32'hBBBB0002;
        applyStimulus(1'b1, 3'b000, 1'b0);

        // Reset state, then a single requester holds the display.
        tick();
        tick();
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_number", number, 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 3'b001, 1'b0);
        tick();
        checkOutput("single_gnt_e1", 32'(gnt), 32'h1);
        checkOutput("single_active_e1", 32'(active), 32'd1);
        tick();
        checkOutput("single_number_e2", number, 32'h12345678);
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 3'b000) done_seen = 1'b1;
        end
        checkOutput("single_gnt_hold", 32'(gnt), 32'h1);
        checkOutput("single_no_done", 32'(done_seen), 32'd0);

        // Full rotation, four cycles per owner.
        applyStimulus(1'b1, 3'b000, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b111, 1'b0);
        tick();
        checkOutput("rot_gnt_e0", 32'(gnt), 32'h1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) checkOutput("rot_gnt_hold", 32'(gnt), 32'h1);
            if (i == 4) begin
                checkOutput("rot_gnt_e4", 32'(gnt), 32'h2);
                checkOutput("rot_done_e4", 32'(done), 32'h1);
            end
            if (i == 5) checkOutput("rot_number_e5", number, 32'hAAAA0001);
            if (i == 8) begin
                checkOutput("rot_gnt_e8", 32'(gnt), 32'h4);
                checkOutput("rot_done_e8", 32'(done), 32'h2);
            end
            if (i == 12) begin
                checkOutput("rot_gnt_e12", 32'(gnt), 32'h1);
                checkOutput("rot_done_e12", 32'(done), 32'h4);
            end
        end

        // Freeze pins requester 0, release lets the full dwell run out.
        applyStimulus(1'b1, 3'b000, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b011, 1'b1);
        tick();
        checkOutput("frz_gnt_e0", 32'(gnt), 32'h1);
        repeat (8) tick();
        checkOutput("frz_gnt_pinned", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 3'b011, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) checkOutput("frz_gnt_before", 32'(gnt), 32'h1);
            if (i == 4) begin
                checkOutput("frz_gnt_after", 32'(gnt), 32'h2);
                checkOutput("frz_done_after", 32'(done), 32'h1);
            end
        end

        // Owner 1 withdraws at count 1 with requester 2 waiting, then all leave.
        applyStimulus(1'b1, 3'b000, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b010, 1'b0);
        tick();
        checkOutput("drop_gnt_e0", 32'(gnt), 32'h2);
        applyStimulus(1'b0, 3'b110, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b100, 1'b0);
        tick();
        checkOutput("drop_gnt_move", 32'(gnt), 32'h4);
        checkOutput("drop_done_move", 32'(done), 32'h2);
        applyStimulus(1'b0, 3'b000, 1'b0);
        tick();
        checkOutput("drop_gnt_idle", 32'(gnt), 32'd0);
        checkOutput("drop_number_idle", number, 32'd0);
        checkOutput("drop_done_idle", 32'(done), 32'h4);

        // Reset in the middle of a grant wins and does not pulse done.
        applyStimulus(1'b0, 3'b111, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 3'b111, 1'b0);
        tick();
        checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mid_number", number, 32'd0);
        checkOutput("rst_mid_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 3'b111, 1'b0);
        tick();
        checkOutput("rst_after_gnt", 32'(gnt), 32'h1);

        // Randomized traffic; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            data0 = $urandom;
            data1 = $urandom;
            data2 = $urandom;
            if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end

        applyStimulus(1'b0, 3'b000, 1'b0);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
